// File: rtl/sw_debounce_sync_if.sv
// sw_debounce_sync_if: switch conditioner bus, raw levels in, debounced levels and edge pulses out
// Ports (signals):
//   SW         raw switch levels, asynchronous to clk
//   sw_db      debounced, clk-synchronous levels
//   sw_rise    one-cycle pulse per channel on a debounced 0->1
//   sw_fall    one-cycle pulse per channel on a debounced 1->0
//   sw_changed OR of all rise/fall bits in the same cycle
// master drives SW and observes the results; slave is the conditioner.
interface sw_debounce_sync_if #(
  parameter int N_SW = 2
);
  logic [N_SW-1:0] SW;
  logic [N_SW-1:0] sw_db;
  logic [N_SW-1:0] sw_rise;
  logic [N_SW-1:0] sw_fall;
  logic            sw_changed;
  modport master (output SW, input sw_db, sw_rise, sw_fall, sw_changed);
  modport slave  (input SW, output sw_db, sw_rise, sw_fall, sw_changed);
endinterface

// File: rtl/sw_debounce_sync.sv
// sw_debounce_sync: synchronise and debounce raw switch levels, with per-channel edge pulses
// Ports:
//   clk    system clock, all state on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    sw_debounce_sync_if slave: SW in; sw_db, sw_rise, sw_fall, sw_changed out
module sw_debounce_sync #(
  parameter int N_SW            = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  sw_debounce_sync_if.slave bus
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [N_SW-1:0]  s1, s2, db, rise, fall, hit;
  logic             chg;
  logic [CNT_W-1:0] cnt [N_SW];
  // hit: the synchronised level has disagreed with sw_db for DEBOUNCE_CYCLES samples in a row
  always_comb begin
    hit = '0;
    for (int i = 0; i < N_SW; i++) hit[i] = (s2[i] != db[i]) && (cnt[i] == LAST);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= '0;
      s2   <= '0;
      db   <= '0;
      rise <= '0;
      fall <= '0;
      chg  <= 1'b0;
      for (int i = 0; i < N_SW; i++) cnt[i] <= '0;
    end else begin
      s1   <= bus.SW;
      s2   <= s1;
      db   <= db ^ hit;
      rise <= hit & s2;
      fall <= hit & ~s2;
      chg  <= |hit;
      // any agreeing sample restarts qualification, so the count never passes LAST
      for (int i = 0; i < N_SW; i++) cnt[i] <= (s2[i] == db[i] || hit[i]) ? '0 : cnt[i] + 1'b1;
    end
  end
  assign bus.sw_db      = db;
  assign bus.sw_rise    = rise;
  assign bus.sw_fall    = fall;
  assign bus.sw_changed = chg;
endmodule

// File: tb/tb_sw_debounce_sync.sv
// tb_sw_debounce_sync: randomized and directed checks of two conditioner builds against a window model
module tb_sw_debounce_sync;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] sw = 2'b00;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  sw_debounce_sync_if #(.N_SW(2)) bus4 ();
  sw_debounce_sync_if #(.N_SW(2)) bus1 ();
  assign bus4.SW = sw;
  assign bus1.SW = sw;
  sw_debounce_sync #(.N_SW(2), .DEBOUNCE_CYCLES(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  sw_debounce_sync #(.N_SW(2), .DEBOUNCE_CYCLES(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  // Reference: a level is accepted when the last D synchronised samples all differ from the current level.
  logic [1:0] swh0 = '0, swh1 = '0, s2v = '0;
  logic [1:0] hs [8];
  logic [1:0] mdb [2], mri [2], mfa [2];
  logic       mch [2];
  initial begin
    foreach (hs[k]) hs[k] = '0;
    for (int u = 0; u < 2; u++) begin mdb[u] = '0; mri[u] = '0; mfa[u] = '0; mch[u] = 1'b0; end
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        swh0 = '0;
        swh1 = '0;
        foreach (hs[k]) hs[k] = '0;
        for (int u = 0; u < 2; u++) begin mdb[u] = '0; mri[u] = '0; mfa[u] = '0; mch[u] = 1'b0; end
      end else begin
        s2v  = swh1;
        swh1 = swh0;
        swh0 = sw;
        for (int k = 7; k > 0; k--) hs[k] = hs[k-1];
        hs[0] = s2v;
        for (int u = 0; u < 2; u++) begin
          int d;
          logic [1:0] nr, nf;
          d = (u == 0) ? 4 : 1;
          nr = '0;
          nf = '0;
          for (int i = 0; i < 2; i++) begin
            bit all;
            all = 1'b1;
            for (int j = 0; j < d; j++) if (hs[j][i] == mdb[u][i]) all = 1'b0;
            if (all) begin
              if (mdb[u][i]) nf[i] = 1'b1; else nr[i] = 1'b1;
              mdb[u][i] = ~mdb[u][i];
            end
          end
          mri[u] = nr;
          mfa[u] = nf;
          mch[u] = |(nr | nf);
        end
      end
    end
  end
  function automatic logic [6:0] obs(int u);
    return (u == 0) ? {bus4.sw_db, bus4.sw_rise, bus4.sw_fall, bus4.sw_changed}
                    : {bus1.sw_db, bus1.sw_rise, bus1.sw_fall, bus1.sw_changed};
  endfunction
  function automatic logic [6:0] mexp(int u);
    return {mdb[u], mri[u], mfa[u], mch[u]};
  endfunction
  task automatic test_reset;
    sw = 2'b11;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (obs(u) !== 7'd0) begin failures++; $display("FAIL reset_state u%0d got=%b exp=%b", u, obs(u), 7'd0); end
    end
    sw = 2'b00;
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        checks++;
        if (obs(u) !== mexp(u)) begin failures++; $display("FAIL reset_idle u%0d t=%0t got=%b exp=%b", u, $time, obs(u), mexp(u)); end
      end
    end
  endtask
  task automatic test_latency;
    int ce [6] = '{0, 0, 1, 2, 3, 0};
    @(negedge clk);
    sw = 2'b01;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      checks++;
      if ({bus4.sw_db, bus4.sw_rise, bus4.sw_changed} !== ((j == 5) ? 5'b01011 : (j > 5) ? 5'b01000 : 5'b00000)) begin
        failures++;
        $display("FAIL latency edge%0d got db=%b rise=%b chg=%b", j, bus4.sw_db, bus4.sw_rise, bus4.sw_changed);
      end
      if (j < 6) begin
        checks++;
        if (int'(u4.cnt[0]) !== ce[j]) begin failures++; $display("FAIL latency_cnt edge%0d got=%0d exp=%0d", j, u4.cnt[0], ce[j]); end
      end
      for (int u = 0; u < 2; u++) begin
        checks++;
        if (obs(u) !== mexp(u)) begin failures++; $display("FAIL latency_model u%0d t=%0t got=%b exp=%b", u, $time, obs(u), mexp(u)); end
      end
    end
  endtask
  task automatic test_glitch;
    logic [1:0] q [$];
    int r4;
    for (int len = 3; len <= 4; len++) begin
      q = {};
      repeat (10) q.push_back(2'b00);
      repeat (len) q.push_back(2'b01);
      repeat (12) q.push_back(2'b00);
      r4 = 0;
      foreach (q[k]) begin
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
          checks++;
          if (obs(u) !== mexp(u)) begin failures++; $display("FAIL glitch_model u%0d t=%0t got=%b exp=%b", u, $time, obs(u), mexp(u)); end
        end
        if (k >= 10) r4 += int'(bus4.sw_rise[0]);
        sw = q[k];
      end
      checks++;
      if (r4 !== len - 3) begin failures++; $display("FAIL glitch_rises len%0d got=%0d exp=%0d", len, r4, len - 3); end
    end
  endtask
  task automatic test_bounce;
    logic [1:0] q [$];
    int r, f;
    bit fv;
    q = {};
    repeat (10) q.push_back(2'b00);
    foreach (q[k]) begin @(negedge clk); sw = q[k]; end
    q = '{2'b10, 2'b00, 2'b10, 2'b10, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10};
    repeat (10) q.push_back(2'b10);
    repeat (3) q.push_back(2'b00);
    q.push_back(2'b10);
    repeat (12) q.push_back(2'b00);
    r = 0;
    f = 0;
    fv = 1'b0;
    foreach (q[k]) begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        checks++;
        if (obs(u) !== mexp(u)) begin failures++; $display("FAIL bounce_model u%0d t=%0t got=%b exp=%b", u, $time, obs(u), mexp(u)); end
      end
      r += $countones(bus4.sw_rise);
      f += $countones(bus4.sw_fall);
      if (bus4.sw_fall == 2'b10) fv = 1'b1;
      sw = q[k];
    end
    repeat (2) @(negedge clk);
    r += $countones(bus4.sw_rise);
    f += $countones(bus4.sw_fall);
    checks++;
    if (r !== 1 || f !== 1 || !fv) begin failures++; $display("FAIL bounce_pulses got rises=%0d falls=%0d fall10=%0d exp 1 1 1", r, f, fv); end
  endtask
  task automatic test_simultaneous;
    int c;
    bit both;
    c = 0;
    both = 1'b0;
    @(negedge clk);
    sw = 2'b11;
    repeat (12) begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        checks++;
        if (obs(u) !== mexp(u)) begin failures++; $display("FAIL simul_model u%0d t=%0t got=%b exp=%b", u, $time, obs(u), mexp(u)); end
      end
      c += int'(bus4.sw_changed);
      if (bus4.sw_rise == 2'b11 && bus4.sw_changed) both = 1'b1;
    end
    checks++;
    if (c !== 1 || !both || bus4.sw_db !== 2'b11) begin
      failures++;
      $display("FAIL simul_pulse got chg_cycles=%0d rise11=%0d db=%b exp 1 1 11", c, both, bus4.sw_db);
    end
  endtask
  task automatic test_reset_mid;
    @(negedge clk);
    sw = 2'b00;
    repeat (10) @(negedge clk);
    sw = 2'b01;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({obs(0), obs(1), u4.cnt[0]} !== '0) begin failures++; $display("FAIL reset_mid_clear got u4=%b u1=%b cnt=%0d exp zeros", obs(0), obs(1), u4.cnt[0]); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if ({bus4.sw_db, bus4.sw_rise} !== {((k >= 6) ? 2'b01 : 2'b00), ((k == 6) ? 2'b01 : 2'b00)}) begin
        failures++;
        $display("FAIL reset_mid_d4 edge%0d got db=%b rise=%b", k, bus4.sw_db, bus4.sw_rise);
      end
      checks++;
      if ({bus1.sw_db, bus1.sw_rise} !== {((k >= 3) ? 2'b01 : 2'b00), ((k == 3) ? 2'b01 : 2'b00)}) begin
        failures++;
        $display("FAIL reset_mid_d1 edge%0d got db=%b rise=%b", k, bus1.sw_db, bus1.sw_rise);
      end
    end
  endtask
  task automatic test_d1_toggle;
    int last;
    last = 1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        checks++;
        if (obs(u) !== mexp(u)) begin failures++; $display("FAIL toggle_model u%0d t=%0t got=%b exp=%b", u, $time, obs(u), mexp(u)); end
      end
      if (bus1.sw_rise[0] || bus1.sw_fall[0]) begin
        checks++;
        if ((bus1.sw_rise[0] && bus1.sw_fall[0]) || int'(bus1.sw_rise[0]) == last) begin
          failures++;
          $display("FAIL toggle_alternate t=%0t got rise=%b fall=%b prev_rise=%0d", $time, bus1.sw_rise[0], bus1.sw_fall[0], last);
        end
        last = int'(bus1.sw_rise[0]);
      end
      if (k % 3 == 2) sw[0] = ~sw[0];
    end
  endtask
  task automatic test_random;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        checks++;
        if (obs(u) !== mexp(u)) begin failures++; $display("FAIL random_model u%0d t=%0t got=%b exp=%b", u, $time, obs(u), mexp(u)); end
      end
      if ($urandom_range(3) == 0) sw = 2'($urandom);
      else if ($urandom_range(15) == 0) begin
        sw = 2'($urandom);
        repeat (6) begin
          @(negedge clk);
          for (int u = 0; u < 2; u++) begin
            checks++;
            if (obs(u) !== mexp(u)) begin failures++; $display("FAIL random_hold u%0d t=%0t got=%b exp=%b", u, $time, obs(u), mexp(u)); end
          end
        end
      end
    end
  endtask
  initial begin
    test_reset;
    test_latency;
    test_glitch;
    test_bounce;
    test_simultaneous;
    test_reset_mid;
    test_d1_toggle;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
